// File: rtl/store_align_unit.sv
// Store aligner: registers one store, emits 1-2 aligned bus beats (req N+1, done N+2 with zero-wait ack).
// Backpressure: O_ready low until the store completes or faults; beats hold until I_bus_ack.
module store_align_unit #(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_valid,
  output logic              O_ready,
  input  logic [1:0]        I_storesel,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [XLEN-1:0]   I_data,
  output logic              O_bus_req,
  output logic [ADDR_W-1:0] O_bus_addr,
  output logic [XLEN-1:0]   O_bus_wdata,
  output logic [XLEN/8-1:0] O_bus_be,
  input  logic              I_bus_ack,
  output logic              O_done,
  output logic              O_fault,
  output logic [ADDR_W-1:0] O_fault_addr
);
  localparam int NB  = XLEN / 8;
  localparam int OFS = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_FAULT} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2*XLEN-1:0]   wdata_q, wdata_d;
  logic [2*NB-1:0]     be_q, be_d;
  logic                split_q, split_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   fault_addr_q, fault_addr_d;

  logic [3:0]          sz;
  logic [OFS-1:0]      off;
  logic [XLEN-1:0]     data_m;
  logic [NB-1:0]       bmask;
  logic [2*XLEN-1:0]   data_sh;
  logic [2*NB-1:0]     be_sh;
  logic                need_split;
  logic                size_bad;
  logic                mis_bad;

  // Alignment is computed over a double-width window so the upper half is the second beat.
  always_comb begin
    sz     = 4'd1 << I_storesel;
    off    = I_addr[OFS-1:0];
    data_m = '0;
    bmask  = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(sz)) begin
        data_m[8*i +: 8] = I_data[8*i +: 8];
        bmask[i]         = 1'b1;
      end
    end
    data_sh    = {{XLEN{1'b0}}, data_m} << (8 * off);
    be_sh      = {{NB{1'b0}}, bmask} << off;
    need_split = (int'(off) + int'(sz)) > NB;
    size_bad   = (XLEN == 32) && (I_storesel == 2'd3);
    // sz-1 wraps to 3'b111 for SD, giving the 8-byte alignment mask.
    mis_bad    = (ALLOW_MISALIGNED == 1'b0) &&
                 ((I_addr[2:0] & (sz[2:0] - 3'd1)) != 3'd0);
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    split_d      = split_q;
    done_d       = 1'b0;
    fault_addr_d = fault_addr_q;
    O_ready      = 1'b0;
    O_bus_req    = 1'b0;
    O_bus_addr   = '0;
    O_bus_wdata  = '0;
    O_bus_be     = '0;
    O_fault      = 1'b0;
    case (state_q)
      S_IDLE: begin
        O_ready = 1'b1;
        if (I_valid) begin
          if (size_bad || mis_bad) begin
            state_d      = S_FAULT;
            fault_addr_d = I_addr;
          end else begin
            state_d = S_BEAT0;
            addr_d  = {I_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
            wdata_d = data_sh;
            be_d    = be_sh;
            split_d = need_split;
          end
        end
      end
      S_BEAT0: begin
        O_bus_req   = 1'b1;
        O_bus_addr  = addr_q;
        O_bus_wdata = wdata_q[XLEN-1:0];
        O_bus_be    = be_q[NB-1:0];
        if (I_bus_ack) begin
          if (split_q) begin
            state_d = S_BEAT1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_BEAT1: begin
        O_bus_req   = 1'b1;
        O_bus_addr  = addr_q + ADDR_W'(NB);
        O_bus_wdata = wdata_q[2*XLEN-1:XLEN];
        O_bus_be    = be_q[2*NB-1:NB];
        if (I_bus_ack) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_FAULT: begin
        O_fault = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      split_q      <= 1'b0;
      done_q       <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      split_q      <= split_d;
      done_q       <= done_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign O_done       = done_q;
  assign O_fault_addr = fault_addr_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench: 32-bit split-capable, 32-bit strict-alignment and 64-bit instances.
module tb_store_align_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Instance A: XLEN=32, misaligned stores split
  logic v_a = 0, ack_a = 0, ready_a, req_a, done_a, fault_a;
  logic [1:0] sel_a = 0;
  logic [31:0] addr_a = 0, data_a = 0, baddr_a, wdata_a, faddr_a;
  logic [3:0] be_a;
  // Instance B: XLEN=32, misaligned stores fault
  logic v_b = 0, ack_b = 0, ready_b, req_b, done_b, fault_b;
  logic [1:0] sel_b = 0;
  logic [31:0] addr_b = 0, data_b = 0, baddr_b, wdata_b, faddr_b;
  logic [3:0] be_b;
  // Instance C: XLEN=64
  logic v_c = 0, ack_c = 0, ready_c, req_c, done_c, fault_c;
  logic [1:0] sel_c = 0;
  logic [31:0] addr_c = 0, baddr_c, faddr_c;
  logic [63:0] data_c = 0, wdata_c;
  logic [7:0] be_c;

  store_align_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut_a (
    .I_clk(clk), .I_rst_n(rst_n), .I_valid(v_a), .O_ready(ready_a), .I_storesel(sel_a),
    .I_addr(addr_a), .I_data(data_a), .O_bus_req(req_a), .O_bus_addr(baddr_a),
    .O_bus_wdata(wdata_a), .O_bus_be(be_a), .I_bus_ack(ack_a), .O_done(done_a),
    .O_fault(fault_a), .O_fault_addr(faddr_a));

  store_align_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut_b (
    .I_clk(clk), .I_rst_n(rst_n), .I_valid(v_b), .O_ready(ready_b), .I_storesel(sel_b),
    .I_addr(addr_b), .I_data(data_b), .O_bus_req(req_b), .O_bus_addr(baddr_b),
    .O_bus_wdata(wdata_b), .O_bus_be(be_b), .I_bus_ack(ack_b), .O_done(done_b),
    .O_fault(fault_b), .O_fault_addr(faddr_b));

  store_align_unit #(.XLEN(64), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut_c (
    .I_clk(clk), .I_rst_n(rst_n), .I_valid(v_c), .O_ready(ready_c), .I_storesel(sel_c),
    .I_addr(addr_c), .I_data(data_c), .O_bus_req(req_c), .O_bus_addr(baddr_c),
    .O_bus_wdata(wdata_c), .O_bus_be(be_c), .I_bus_ack(ack_c), .O_done(done_c),
    .O_fault(fault_c), .O_fault_addr(faddr_c));

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] a0;
    logic [31:0] w0;
    logic [3:0]  be0;
    logic        split;
    logic [31:0] w1;
    logic [3:0]  be1;
    int          dly;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk("ready_idle", ready_a, 1);
    v_a = 1; sel_a = v.sel; addr_a = v.addr; data_a = v.data;
    @(negedge clk);
    v_a = 0;
    chk("b0_req", req_a, 1);
    chk("b0_ready_low", ready_a, 0);
    chk("b0_addr", baddr_a, v.a0);
    chk("b0_wdata", wdata_a, v.w0);
    chk("b0_be", be_a, v.be0);
    for (int k = 0; k < v.dly; k++) begin
      @(negedge clk);
      chk("b0_hold_req", req_a, 1);
      chk("b0_hold_addr", baddr_a, v.a0);
      chk("b0_hold_wdata", wdata_a, v.w0);
      chk("b0_hold_be", be_a, v.be0);
      chk("b0_hold_nodone", done_a, 0);
    end
    ack_a = 1;
    @(negedge clk);
    ack_a = 0;
    if (v.split) begin
      chk("b1_req", req_a, 1);
      chk("b1_addr", baddr_a, v.a0 + 32'd4);
      chk("b1_wdata", wdata_a, v.w1);
      chk("b1_be", be_a, v.be1);
      chk("b1_nodone", done_a, 0);
      ack_a = 1;
      @(negedge clk);
      ack_a = 0;
    end
    chk("done_pulse", done_a, 1);
    chk("done_req_low", req_a, 0);
    chk("done_be_zero", be_a, 0);
    chk("done_wdata_zero", wdata_a, 0);
    chk("done_addr_zero", baddr_a, 0);
    chk("done_ready", ready_a, 1);
    chk("done_nofault", fault_a, 0);
    @(negedge clk);
    chk("done_one_cycle", done_a, 0);
  endtask

  initial begin
    //            sel    addr          data          a0            w0            be0      split w1            be1      dly
    vecs[0] = '{2'd0, 32'h0000_1003, 32'hAABB_CCDD, 32'h0000_1000, 32'hDD00_0000, 4'b1000, 1'b0, 32'h0,        4'b0000, 0};
    vecs[1] = '{2'd1, 32'h0000_1002, 32'hFFFF_1234, 32'h0000_1000, 32'h1234_0000, 4'b1100, 1'b0, 32'h0,        4'b0000, 0};
    vecs[2] = '{2'd2, 32'h0000_1006, 32'h1122_3344, 32'h0000_1004, 32'h3344_0000, 4'b1100, 1'b1, 32'h0000_1122, 4'b0011, 3};
    vecs[3] = '{2'd2, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0000_2000, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0,        4'b0000, 0};
    vecs[4] = '{2'd0, 32'h0000_2001, 32'h0000_00A5, 32'h0000_2000, 32'h0000_A500, 4'b0010, 1'b0, 32'h0,        4'b0000, 1};
    vecs[5] = '{2'd1, 32'h0000_3003, 32'h0000_BEEF, 32'h0000_3000, 32'hEF00_0000, 4'b1000, 1'b1, 32'h0000_00BE, 4'b0001, 0};
    vecs[6] = '{2'd2, 32'h0000_4001, 32'hCAFE_F00D, 32'h0000_4000, 32'hFEF0_0D00, 4'b1110, 1'b1, 32'h0000_00CA, 4'b0001, 0};
    vecs[7] = '{2'd1, 32'h0000_4000, 32'h1234_ABCD, 32'h0000_4000, 32'h0000_ABCD, 4'b0011, 1'b0, 32'h0,        4'b0000, 2};

    #12;
    chk("rst_ready", ready_a, 1);
    chk("rst_req", req_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_fault", fault_a, 0);
    chk("rst_faddr", faddr_a, 0);
    chk("rst_be", be_a, 0);
    @(negedge clk);
    rst_n = 1;

    // Ack with no request outstanding must be ignored
    @(negedge clk);
    ack_a = 1;
    @(negedge clk);
    ack_a = 0;
    chk("stray_ack_ready", ready_a, 1);
    chk("stray_ack_req", req_a, 0);
    chk("stray_ack_done", done_a, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // SD on a 32-bit bus faults even when misalignment is allowed
    @(negedge clk);
    v_a = 1; sel_a = 2'd3; addr_a = 32'h0000_5008; data_a = 32'h1;
    @(negedge clk);
    v_a = 0;
    chk("a_sd_fault", fault_a, 1);
    chk("a_sd_noreq", req_a, 0);
    chk("a_sd_faddr", faddr_a, 32'h0000_5008);
    @(negedge clk);
    chk("a_sd_fault_clr", fault_a, 0);
    chk("a_sd_nodone", done_a, 0);

    // Strict-alignment instance
    @(negedge clk);
    v_b = 1; sel_b = 2'd2; addr_b = 32'h0000_1006; data_b = 32'h1122_3344;
    @(negedge clk);
    v_b = 0;
    chk("b_sw_fault", fault_b, 1);
    chk("b_sw_noreq", req_b, 0);
    chk("b_sw_faddr", faddr_b, 32'h0000_1006);
    chk("b_sw_ready_low", ready_b, 0);
    @(negedge clk);
    chk("b_sw_fault_clr", fault_b, 0);
    chk("b_sw_ready", ready_b, 1);
    chk("b_sw_nodone", done_b, 0);
    chk("b_faddr_held", faddr_b, 32'h0000_1006);
    v_b = 1; sel_b = 2'd3; addr_b = 32'h0000_1000;
    @(negedge clk);
    v_b = 0;
    chk("b_sd_fault", fault_b, 1);
    chk("b_sd_faddr", faddr_b, 32'h0000_1000);
    @(negedge clk);
    v_b = 1; sel_b = 2'd1; addr_b = 32'h0000_2001;
    @(negedge clk);
    v_b = 0;
    chk("b_sh_odd_fault", fault_b, 1);
    chk("b_sh_odd_faddr", faddr_b, 32'h0000_2001);
    @(negedge clk);
    v_b = 1; sel_b = 2'd2; addr_b = 32'h0000_3008; data_b = 32'h5566_7788;
    @(negedge clk);
    v_b = 0;
    chk("b_aligned_nofault", fault_b, 0);
    chk("b_aligned_req", req_b, 1);
    chk("b_aligned_addr", baddr_b, 32'h0000_3008);
    chk("b_aligned_wdata", wdata_b, 32'h5566_7788);
    chk("b_aligned_be", be_b, 4'b1111);
    ack_b = 1;
    @(negedge clk);
    ack_b = 0;
    chk("b_aligned_done", done_b, 1);

    // 64-bit: SD then an SB accepted in the done cycle
    @(negedge clk);
    v_c = 1; sel_c = 2'd3; addr_c = 32'h0000_2000; data_c = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    v_c = 0;
    chk("c_sd_req", req_c, 1);
    chk("c_sd_addr", baddr_c, 32'h0000_2000);
    chk("c_sd_wdata", wdata_c, 64'h0123_4567_89AB_CDEF);
    chk("c_sd_be", be_c, 8'hFF);
    ack_c = 1;
    @(negedge clk);
    ack_c = 0;
    chk("c_sd_done", done_c, 1);
    chk("c_done_ready", ready_c, 1);
    v_c = 1; sel_c = 2'd0; addr_c = 32'h0000_2005; data_c = 64'hFFFF_FFFF_FFFF_FF77;
    @(negedge clk);
    v_c = 0;
    chk("c_sb_req", req_c, 1);
    chk("c_sb_addr", baddr_c, 32'h0000_2000);
    chk("c_sb_wdata", wdata_c, 64'h0000_7700_0000_0000);
    chk("c_sb_be", be_c, 8'h20);
    chk("c_sb_nodone", done_c, 0);
    ack_c = 1;
    @(negedge clk);
    ack_c = 0;
    chk("c_sb_done", done_c, 1);

    // Reset while the second beat of a split store is pending
    @(negedge clk);
    v_a = 1; sel_a = 2'd2; addr_a = 32'h0000_1006; data_a = 32'h1122_3344;
    @(negedge clk);
    v_a = 0;
    ack_a = 1;
    @(negedge clk);
    ack_a = 0;
    chk("rst_mid_in_b1", req_a, 1);
    chk("rst_mid_b1_addr", baddr_a, 32'h0000_1008);
    rst_n = 0;
    #1;
    chk("rst_mid_req", req_a, 0);
    chk("rst_mid_be", be_a, 0);
    chk("rst_mid_wdata", wdata_a, 0);
    chk("rst_mid_addr", baddr_a, 0);
    chk("rst_mid_done", done_a, 0);
    chk("rst_mid_faddr", faddr_a, 0);
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_nodone", done_a, 0);
      chk("post_rst_ready", ready_a, 1);
      chk("post_rst_noreq", req_a, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // done and fault must never coincide on any instance
  always @(negedge clk) begin
    if (rst_n && ((done_a && fault_a) || (done_b && fault_b) || (done_c && fault_c))) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_fault_overlap: got done and fault high together, required at most one");
    end
  end

endmodule
